// File: rtl/ball_motion.sv
// ball_motion: once-per-frame ball physics with wall/keeper bounces, sequential hoop scoring and
// post-goal serve pause. Optional macro BALL_SPEEDUP_EN: keeper hits also raise |vx| up to MAX_SPEED.
module ball_motion #(
  parameter int PLAYER_RADIUS = 25,
  parameter int GOAL_RADIUS   = 40,
  parameter int BALL_RADIUS   = 5,
  parameter int INIT_VX       = 2,
  parameter int INIT_VY       = 1,
  parameter int PAUSE_FRAMES  = 60,
  parameter int MAX_SPEED     = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [9:0]  team1_ver_pos,
  input  logic [9:0]  team2_ver_pos,
  output logic [18:0] ball_x,
  output logic [18:0] ball_y,
  output logic [3:0]  score_blue,
  output logic [3:0]  score_red,
  output logic        goal_pulse
);

  localparam logic signed [10:0] XMin     = 11'(144 + BALL_RADIUS);
  localparam logic signed [10:0] XMax     = 11'(683 - BALL_RADIUS);
  localparam logic signed [10:0] YMin     = 11'(35 + BALL_RADIUS);
  localparam logic signed [10:0] YMax     = 11'(514 - BALL_RADIUS);
  localparam logic signed [10:0] Keeper1X = 11'sd240;
  localparam logic signed [10:0] Keeper2X = 11'sd560;
  localparam logic [10:0]        HitReach = 11'(PLAYER_RADIUS + BALL_RADIUS);
  localparam logic [20:0]        GoalR2   = 21'((GOAL_RADIUS - 2) * (GOAL_RADIUS - 2));
  localparam logic [9:0]         CentreX  = 10'd413;
  localparam logic [9:0]         CentreY  = 10'd274;
  localparam logic signed [4:0]  ServeVx  = 5'(INIT_VX);
  localparam logic signed [4:0]  ServeVy  = 5'(INIT_VY);
  localparam int                 CntW     = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [CntW-1:0]    PauseLast = CntW'(PAUSE_FRAMES - 1);
  localparam logic [4:0]         SpeedCap = 5'(MAX_SPEED);
`ifdef BALL_SPEEDUP_EN
  localparam logic [4:0]         SpeedStep = 5'd1;
`else
  localparam logic [4:0]         SpeedStep = 5'd0;
`endif

  typedef enum logic [1:0] {StMove, StCheck, StPause} state_e;

  state_e            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic signed [4:0] vx_q, vx_d, vy_q, vy_d;
  logic [2:0]        idx_q, idx_d;
  logic [CntW-1:0]   pause_q, pause_d;
  logic [3:0]        blue_q, blue_d, red_q, red_d;
  logic              goal_q, goal_d;

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    return v[10] ? 11'(-v) : 11'(v);
  endfunction

  logic signed [10:0] px, py, nx, ny, k1y, k2y;
  logic               vx_pos, vx_neg, hit1, hit2, x_wall, y_wall;
  logic [4:0]         vx_mag, kick_mag;
  logic signed [4:0]  vx_kick;

  always_comb begin
    px     = signed'({1'b0, x_q});
    py     = signed'({1'b0, y_q});
    nx     = px + {{6{vx_q[4]}}, vx_q};
    ny     = py + {{6{vy_q[4]}}, vy_q};
    k1y    = signed'({1'b0, team1_ver_pos});
    k2y    = signed'({1'b0, team2_ver_pos});
    vx_neg = vx_q[4];
    vx_pos = !vx_q[4] && (vx_q != 5'sd0);
    // A keeper only deflects a ball that is still travelling toward its centre line.
    hit1   = (abs11(nx - Keeper1X) <= HitReach) && (abs11(ny - k1y) <= HitReach) &&
             ((vx_pos && (nx < Keeper1X)) || (vx_neg && (nx > Keeper1X)));
    hit2   = (abs11(nx - Keeper2X) <= HitReach) && (abs11(ny - k2y) <= HitReach) &&
             ((vx_pos && (nx < Keeper2X)) || (vx_neg && (nx > Keeper2X)));
    vx_mag   = vx_neg ? 5'(-vx_q) : 5'(vx_q);
    kick_mag = vx_mag + SpeedStep;
    if ((SpeedStep != 5'd0) && (kick_mag > SpeedCap)) kick_mag = SpeedCap;
    vx_kick  = vx_neg ? kick_mag : (5'd0 - kick_mag);
    x_wall   = (nx < XMin) || (nx > XMax);
    y_wall   = (ny < YMin) || (ny > YMax);
  end

  logic signed [10:0] hx, hy;
  logic [10:0]        adx, ady;
  logic [20:0]        dist2;
  logic               hoop_hit;

  always_comb begin
    hy = (idx_q < 3'd3) ? 11'sd100 : 11'sd450;
    case (idx_q)
      3'd0, 3'd3: hx = 11'sd300;
      3'd1, 3'd4: hx = 11'sd400;
      default:    hx = 11'sd500;
    endcase
    adx      = abs11(px - hx);
    ady      = abs11(py - hy);
    dist2    = 21'(adx) * 21'(adx) + 21'(ady) * 21'(ady);
    hoop_hit = dist2 < GoalR2;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    idx_d   = idx_q;
    pause_d = pause_q;
    blue_d  = blue_q;
    red_d   = red_q;
    goal_d  = 1'b0;
    unique case (state_q)
      StMove: begin
        if (frame_tick) begin
          x_d = (nx < XMin) ? XMin[9:0] : ((nx > XMax) ? XMax[9:0] : nx[9:0]);
          y_d = (ny < YMin) ? YMin[9:0] : ((ny > YMax) ? YMax[9:0] : ny[9:0]);
          // Keeper and wall on the same axis still flip vx only once.
          if (hit1 || hit2) vx_d = vx_kick;
          else if (x_wall)  vx_d = -vx_q;
          if (y_wall) vy_d = -vy_q;
          idx_d   = 3'd0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (hoop_hit) begin
          goal_d = 1'b1;
          if (idx_q < 3'd3) blue_d = (blue_q == 4'd9) ? blue_q : blue_q + 4'd1;
          else              red_d  = (red_q == 4'd9) ? red_q : red_q + 4'd1;
          pause_d = '0;
          state_d = StPause;
        end else if (idx_q == 3'd5) begin
          state_d = StMove;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StPause: begin
        if (frame_tick) begin
          if (pause_q == PauseLast) begin
            x_d     = CentreX;
            y_d     = CentreY;
            vx_d    = ServeVx;
            vy_d    = ServeVy;
            pause_d = '0;
            state_d = StMove;
          end else begin
            pause_d = pause_q + 1'b1;
          end
        end
      end
      default: state_d = StMove;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StMove;
      x_q     <= CentreX;
      y_q     <= CentreY;
      vx_q    <= ServeVx;
      vy_q    <= ServeVy;
      idx_q   <= 3'd0;
      pause_q <= '0;
      blue_q  <= 4'd0;
      red_q   <= 4'd0;
      goal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      idx_q   <= idx_d;
      pause_q <= pause_d;
      blue_q  <= blue_d;
      red_q   <= red_d;
      goal_q  <= goal_d;
    end
  end

  assign ball_x     = {9'd0, x_q};
  assign ball_y     = {9'd0, y_q};
  assign score_blue = blue_q;
  assign score_red  = red_q;
  assign goal_pulse = goal_q;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: randomized frames checked every cycle against a frame-level physics model,
// plus directed wall, keeper, goal/pause, saturation and reset scenarios.
module tb_ball_motion;

  logic        clk = 1'b0;
  logic        reset, frame_tick;
  logic [9:0]  team1_ver_pos, team2_ver_pos;
  logic [18:0] ball_x, ball_y;
  logic [3:0]  score_blue, score_red;
  logic        goal_pulse;

  always #5 clk = ~clk;

  ball_motion dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .team1_ver_pos (team1_ver_pos),
    .team2_ver_pos (team2_ver_pos),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .score_blue    (score_blue),
    .score_red     (score_red),
    .goal_pulse    (goal_pulse)
  );

  localparam int MaxSpeed = 6;
`ifdef BALL_SPEEDUP_EN
  localparam int KickX = 528;
`else
  localparam int KickX = 529;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Frame-level model state
  int mx, my, mvx, mvy, msb, msr, mpaused, mpcnt;
  int hoop_x[6] = '{300, 400, 500, 300, 400, 500};
  int hoop_y[6] = '{100, 100, 100, 450, 450, 450};

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_reset();
    mx = 413; my = 274; mvx = 2; mvy = 1;
    msb = 0; msr = 0; mpaused = 0; mpcnt = 0;
  endfunction

  function automatic int keeper_hits(input int kx, input int ky, input int nx, input int ny);
    return (iabs(nx - kx) <= 30 && iabs(ny - ky) <= 30 && (kx - nx) * mvx > 0) ? 1 : 0;
  endfunction

  // Advances one moving frame; returns the scoring hoop index or -1.
  function automatic int model_move(input int k1, input int k2);
    int nx, ny, kick, xw, mag;
    nx = mx + mvx;
    ny = my + mvy;
    kick = keeper_hits(240, k1, nx, ny) | keeper_hits(560, k2, nx, ny);
    xw = 0;
    if (nx < 149)      begin mx = 149; xw = 1; end
    else if (nx > 678) begin mx = 678; xw = 1; end
    else               mx = nx;
    if (kick != 0) begin
      mag = iabs(mvx);
`ifdef BALL_SPEEDUP_EN
      mag = (mag + 1 > MaxSpeed) ? MaxSpeed : mag + 1;
`endif
      mvx = (mvx > 0) ? -mag : mag;
    end else if (xw != 0) begin
      mvx = -mvx;
    end
    if (ny < 40)       begin my = 40;  mvy = -mvy; end
    else if (ny > 509) begin my = 509; mvy = -mvy; end
    else               my = ny;
    for (int h = 0; h < 6; h++) begin
      if ((mx - hoop_x[h]) * (mx - hoop_x[h]) + (my - hoop_y[h]) * (my - hoop_y[h]) < 38 * 38) begin
        if (h < 3) msb = (msb < 9) ? msb + 1 : 9;
        else       msr = (msr < 9) ? msr + 1 : 9;
        mpaused = 1;
        mpcnt = 0;
        return h;
      end
    end
    return -1;
  endfunction

  function automatic void model_pause_tick();
    mpcnt++;
    if (mpcnt == 60) begin
      mx = 413; my = 274; mvx = 2; mvy = 1;
      mpaused = 0; mpcnt = 0;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One frame: tick, then every cycle until the next tick is checked against the model.
  task automatic run_frame(input string tag, input int k1, input int k2, input int drop_at);
    int h, ob, orr, gap, eb, er;
    bit paused_before, ep;
    @(negedge clk);
    vectors++;
    if ({ball_x, ball_y, score_blue, score_red, goal_pulse} !==
        {19'(mx), 19'(my), 4'(msb), 4'(msr), 1'b0}) begin
      miscompares++;
      $display("FAIL %s pre-tick: got x=%0d y=%0d blue=%0d red=%0d pulse=%0b, want x=%0d y=%0d blue=%0d red=%0d pulse=0",
               tag, ball_x, ball_y, score_blue, score_red, goal_pulse, mx, my, msb, msr);
    end
    team1_ver_pos = 10'(k1);
    team2_ver_pos = 10'(k2);
    frame_tick = 1'b1;
    ob = msb;
    orr = msr;
    paused_before = (mpaused != 0);
    if (paused_before) begin
      model_pause_tick();
      h = -1;
      gap = 2;
    end else begin
      h = model_move(k1, k2);
      gap = 8 + $urandom_range(0, 2);
    end
    for (int j = 1; j < gap; j++) begin
      @(negedge clk);
      frame_tick = (!paused_before && h < 0 && j == drop_at);
      team1_ver_pos = 10'($urandom);
      team2_ver_pos = 10'($urandom);
      ep = (h >= 0 && j == h + 2);
      eb = (h >= 0 && j < h + 2) ? ob : msb;
      er = (h >= 0 && j < h + 2) ? orr : msr;
      vectors++;
      if ({ball_x, ball_y, score_blue, score_red, goal_pulse} !==
          {19'(mx), 19'(my), 4'(eb), 4'(er), ep}) begin
        miscompares++;
        $display("FAIL %s lat=%0d: got x=%0d y=%0d blue=%0d red=%0d pulse=%0b, want x=%0d y=%0d blue=%0d red=%0d pulse=%0b",
                 tag, j, ball_x, ball_y, score_blue, score_red, goal_pulse, mx, my, eb, er, ep);
      end
    end
    frame_tick = 1'b0;
  endtask

  function automatic int rand_drop();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : 0;
  endfunction

  task automatic test_reset();
    do_reset();
    vectors++;
    if (ball_x !== 19'd413 || ball_y !== 19'd274 || score_blue !== 4'd0 || score_red !== 4'd0 ||
        goal_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got x=%0d y=%0d blue=%0d red=%0d pulse=%0b, want 413 274 0 0 0",
               ball_x, ball_y, score_blue, score_red, goal_pulse);
    end
  endtask

  task automatic test_free_flight();
    do_reset();
    for (int i = 0; i < 3; i++) run_frame("free_flight", 0, 0, 0);
    vectors++;
    if (ball_x !== 19'd419 || ball_y !== 19'd277) begin
      miscompares++;
      $display("FAIL three_ticks: got (%0d,%0d), want (419,277)", ball_x, ball_y);
    end
  endtask

  task automatic test_wall();
    do_reset();
    for (int i = 0; i < 133; i++) run_frame("wall", 0, 0, rand_drop());
    vectors++;
    if (ball_x !== 19'd678 || ball_y !== 19'd407) begin
      miscompares++;
      $display("FAIL wall_clamp: got (%0d,%0d), want (678,407)", ball_x, ball_y);
    end
    run_frame("wall", 0, 0, 0);
    vectors++;
    if (ball_x !== 19'd676 || ball_y !== 19'd408) begin
      miscompares++;
      $display("FAIL wall_reverse: got (%0d,%0d), want (676,408)", ball_x, ball_y);
    end
  endtask

  task automatic test_keeper();
    do_reset();
    for (int i = 0; i < 59; i++) run_frame("keeper", 0, 333, 0);
    vectors++;
    if (ball_x !== 19'd531 || ball_y !== 19'd333) begin
      miscompares++;
      $display("FAIL keeper_unclamped: got (%0d,%0d), want (531,333)", ball_x, ball_y);
    end
    run_frame("keeper", 0, 333, 0);
    vectors++;
    if (ball_x !== 19'(KickX) || ball_y !== 19'd334) begin
      miscompares++;
      $display("FAIL keeper_deflect: got (%0d,%0d), want (%0d,334)", ball_x, ball_y, KickX);
    end
    for (int i = 0; i < 200; i++)
      run_frame("keeper_track", my + $urandom_range(0, 40) - 20, my + $urandom_range(0, 40) - 20,
                rand_drop());
  endtask

  task automatic test_goal_pause_saturation();
    int frames, goals;
    bit was;
    do_reset();
    frames = 0;
    while (mpaused == 0 && frames < 400) begin
      run_frame("serve_path", 0, 0, rand_drop());
      frames++;
    end
    vectors++;
    if (score_red !== 4'd1 || score_blue !== 4'd0 || ball_x !== 19'd418 || ball_y !== 19'd482) begin
      miscompares++;
      $display("FAIL hoop4_goal: got red=%0d blue=%0d at (%0d,%0d), want red=1 blue=0 at (418,482)",
               score_red, score_blue, ball_x, ball_y);
    end
    for (int i = 0; i < 59; i++) run_frame("pause", 0, 0, 0);
    vectors++;
    if (ball_x !== 19'd418 || ball_y !== 19'd482) begin
      miscompares++;
      $display("FAIL pause_frozen: got (%0d,%0d), want (418,482)", ball_x, ball_y);
    end
    run_frame("pause", 0, 0, 0);
    vectors++;
    if (ball_x !== 19'd413 || ball_y !== 19'd274) begin
      miscompares++;
      $display("FAIL reserve: got (%0d,%0d), want (413,274)", ball_x, ball_y);
    end
    goals = 1;
    frames = 0;
    while (goals < 10 && frames < 4000) begin
      was = (mpaused != 0);
      run_frame("saturate", 0, 0, rand_drop());
      if (!was && mpaused != 0) goals++;
      frames++;
    end
    vectors++;
    if (score_red !== 4'd9 || score_blue !== 4'd0) begin
      miscompares++;
      $display("FAIL score_saturation: got red=%0d blue=%0d, want red=9 blue=0", score_red, score_blue);
    end
    for (int i = 0; i < 10; i++) run_frame("pause_pre_reset", 0, 0, 0);
    do_reset();
    vectors++;
    if (ball_x !== 19'd413 || ball_y !== 19'd274 || score_blue !== 4'd0 || score_red !== 4'd0 ||
        goal_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_pause: got x=%0d y=%0d blue=%0d red=%0d pulse=%0b, want 413 274 0 0 0",
               ball_x, ball_y, score_blue, score_red, goal_pulse);
    end
    for (int i = 0; i < 3; i++) run_frame("after_pause_reset", 0, 0, 0);
    vectors++;
    if (ball_x !== 19'd419 || ball_y !== 19'd277) begin
      miscompares++;
      $display("FAIL move_after_reset: got (%0d,%0d), want (419,277)", ball_x, ball_y);
    end
  endtask

  task automatic test_reset_mid_check();
    do_reset();
    @(negedge clk);
    team1_ver_pos = 10'd0;
    team2_ver_pos = 10'd0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    vectors++;
    if (ball_x !== 19'd413 || ball_y !== 19'd274 || score_blue !== 4'd0 || score_red !== 4'd0 ||
        goal_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_check: got x=%0d y=%0d blue=%0d red=%0d pulse=%0b, want 413 274 0 0 0",
               ball_x, ball_y, score_blue, score_red, goal_pulse);
    end
    for (int i = 0; i < 2; i++) run_frame("after_check_reset", 0, 0, 0);
  endtask

  task automatic test_rally();
    int k1, k2;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        k1 = $urandom_range(0, 1023);
        k2 = $urandom_range(0, 1023);
      end else begin
        k1 = my + $urandom_range(0, 60) - 30;
        k2 = my + $urandom_range(0, 60) - 30;
      end
      run_frame("rally", k1, k2, rand_drop());
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    team1_ver_pos = 10'd0;
    team2_ver_pos = 10'd0;
    model_reset();
    test_reset();
    test_free_flight();
    test_wall();
    test_keeper();
    test_goal_pause_saturation();
    test_reset_mid_check();
    test_rally();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
